// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// Module   : mc_control
// Purpose  : Multi-cycle Moore control FSM for a 32-bit datapath with a
//            retired-instruction counter and a debug state port.
// Revision : 1.0 - initial release
// ============================================================================
module mc_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Opcode,
    output logic        PCWrite,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        ALUSrcA,
    output logic        RegWrite,
    output logic        BranchType,
    output logic        LUI,
    output logic [1:0]  PCSource,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  ALUOp,
    output logic [3:0]  State,
    output logic        Halted,
    output logic [15:0] InstrCount
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWR  = 4'd4,
        S_WB     = 4'd5,
        S_BRANCH = 4'd6,
        S_JUMP   = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    localparam logic [5:0] c_OP_NOP  = 6'h00;
    localparam logic [5:0] c_OP_ADD  = 6'h01;
    localparam logic [5:0] c_OP_SUB  = 6'h02;
    localparam logic [5:0] c_OP_AND  = 6'h03;
    localparam logic [5:0] c_OP_OR   = 6'h04;
    localparam logic [5:0] c_OP_ADDI = 6'h05;
    localparam logic [5:0] c_OP_ORI  = 6'h06;
    localparam logic [5:0] c_OP_LUI  = 6'h07;
    localparam logic [5:0] c_OP_LW   = 6'h08;
    localparam logic [5:0] c_OP_SW   = 6'h09;
    localparam logic [5:0] c_OP_BEQ  = 6'h0A;
    localparam logic [5:0] c_OP_BNE  = 6'h0B;
    localparam logic [5:0] c_OP_J    = 6'h0C;
    localparam logic [5:0] c_OP_HALT = 6'h3F;

    localparam logic [3:0] c_ALU_AND   = 4'b0000;
    localparam logic [3:0] c_ALU_OR    = 4'b0001;
    localparam logic [3:0] c_ALU_ADD   = 4'b0010;
    localparam logic [3:0] c_ALU_SUB   = 4'b0110;
    localparam logic [3:0] c_ALU_PASSA = 4'b1000;

    localparam logic [2:0] c_CLS_NOP  = 3'd0;
    localparam logic [2:0] c_CLS_ALU  = 3'd1;
    localparam logic [2:0] c_CLS_LW   = 3'd2;
    localparam logic [2:0] c_CLS_SW   = 3'd3;
    localparam logic [2:0] c_CLS_BR   = 3'd4;
    localparam logic [2:0] c_CLS_JMP  = 3'd5;
    localparam logic [2:0] c_CLS_HALT = 3'd6;

    // Unlisted opcodes fall into the NOP class.
    function automatic logic [2:0] op_class(input logic [5:0] op);
        case (op)
            c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR,
            c_OP_ADDI, c_OP_ORI, c_OP_LUI: op_class = c_CLS_ALU;
            c_OP_LW:                       op_class = c_CLS_LW;
            c_OP_SW:                       op_class = c_CLS_SW;
            c_OP_BEQ, c_OP_BNE:            op_class = c_CLS_BR;
            c_OP_J:                        op_class = c_CLS_JMP;
            c_OP_HALT:                     op_class = c_CLS_HALT;
            default:                       op_class = c_CLS_NOP;
        endcase
    endfunction

    state_t      r_state;
    logic [5:0]  r_opcode;
    logic [15:0] r_instr_count;
    logic [2:0]  w_dec_cls;

    assign w_dec_cls = op_class(Opcode);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_FETCH;
            r_opcode      <= c_OP_NOP;
            r_instr_count <= 16'd0;
        end else begin
            case (r_state)
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    r_opcode <= Opcode;
                    case (w_dec_cls)
                        c_CLS_ALU:  r_state <= S_EXEC;
                        c_CLS_LW:   r_state <= S_MEMRD;
                        c_CLS_SW:   r_state <= S_MEMWR;
                        c_CLS_BR:   r_state <= S_BRANCH;
                        c_CLS_JMP:  r_state <= S_JUMP;
                        c_CLS_HALT: r_state <= S_HALT;
                        default: begin
                            r_state       <= S_FETCH;
                            r_instr_count <= r_instr_count + 16'd1;
                        end
                    endcase
                end
                S_EXEC, S_MEMRD: r_state <= S_WB;
                // Final state of every non-NOP instruction: retire it.
                S_WB, S_MEMWR, S_BRANCH, S_JUMP: begin
                    r_state       <= S_FETCH;
                    r_instr_count <= r_instr_count + 16'd1;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Decoded from registers only; reset gates everything low asynchronously.
    always_comb begin
        PCWrite    = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcA    = 1'b0;
        RegWrite   = 1'b0;
        BranchType = 1'b0;
        LUI        = 1'b0;
        PCSource   = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = c_ALU_AND;
        Halted     = 1'b0;
        if (reset) begin
            case (r_state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = 1'b1;
                    ALUSrcB = 2'b01;
                    ALUOp   = c_ALU_ADD;
                    PCWrite = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    case (r_opcode)
                        c_OP_SUB:  ALUOp = c_ALU_SUB;
                        c_OP_AND:  ALUOp = c_ALU_AND;
                        c_OP_OR:   ALUOp = c_ALU_OR;
                        c_OP_ADDI: begin
                            ALUSrcB = 2'b10;
                            ALUOp   = c_ALU_ADD;
                        end
                        c_OP_ORI, c_OP_LUI: begin
                            ALUSrcB = 2'b11;
                            ALUOp   = c_ALU_OR;
                        end
                        default:   ALUOp = c_ALU_ADD;
                    endcase
                end
                S_MEMWR: MemWrite = 1'b1;
                S_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = (r_opcode == c_OP_LW);
                    LUI      = (r_opcode == c_OP_LUI);
                end
                S_BRANCH: begin
                    PCWrite    = 1'b1;
                    ALUOp      = c_ALU_PASSA;
                    BranchType = (r_opcode == c_OP_BNE);
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                S_HALT:  Halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign State      = r_state;
    assign InstrCount = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control
// Purpose  : Directed scoreboard bench for the mc_control FSM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_control;

    logic        clk;
    logic        reset;
    logic [5:0]  Opcode;
    logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
    logic        ALUSrcA, RegWrite, BranchType, LUI;
    logic [1:0]  PCSource, ALUSrcB;
    logic [3:0]  ALUOp;
    logic [3:0]  State;
    logic        Halted;
    logic [15:0] InstrCount;
    logic [17:0] dut_ctrl;

    typedef struct {
        logic [3:0]  st;
        logic [17:0] ctrl;
        logic        halted;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] exp_cnt  = 16'd0;

    mc_control dut (
        .clk        (clk),
        .reset      (reset),
        .Opcode     (Opcode),
        .PCWrite    (PCWrite),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .MemtoReg   (MemtoReg),
        .ALUSrcA    (ALUSrcA),
        .RegWrite   (RegWrite),
        .BranchType (BranchType),
        .LUI        (LUI),
        .PCSource   (PCSource),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .State      (State),
        .Halted     (Halted),
        .InstrCount (InstrCount)
    );

    assign dut_ctrl = {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                       ALUSrcA, RegWrite, BranchType, LUI, PCSource, ALUSrcB, ALUOp};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference control word for a state/opcode pair.
    function automatic logic [17:0] model_ctrl(input logic [3:0] st, input logic [5:0] op);
        logic       pcw, iord, mr, mw, irw, m2r, asa, rw, bt, lui;
        logic [1:0] pcs, asb;
        logic [3:0] aop;
        {pcw, iord, mr, mw, irw, m2r, asa, rw, bt, lui} = 10'd0;
        pcs = 2'b00;
        asb = 2'b00;
        aop = 4'b0000;
        case (st)
            4'd0: begin pcw = 1; mr = 1; irw = 1; asb = 2'b01; aop = 4'b0010; end
            4'd2: begin
                asa = 1;
                case (op)
                    6'h01: begin asb = 2'b00; aop = 4'b0010; end
                    6'h02: begin asb = 2'b00; aop = 4'b0110; end
                    6'h03: begin asb = 2'b00; aop = 4'b0000; end
                    6'h04: begin asb = 2'b00; aop = 4'b0001; end
                    6'h05: begin asb = 2'b10; aop = 4'b0010; end
                    6'h06: begin asb = 2'b11; aop = 4'b0001; end
                    6'h07: begin asb = 2'b11; aop = 4'b0001; end
                    default: ;
                endcase
            end
            4'd4: mw = 1;
            4'd5: begin rw = 1; m2r = (op == 6'h08); lui = (op == 6'h07); end
            4'd6: begin pcw = 1; aop = 4'b1000; bt = (op == 6'h0B); end
            4'd7: begin pcw = 1; pcs = 2'b10; end
            default: ;
        endcase
        return {pcw, iord, mr, mw, irw, m2r, asa, rw, bt, lui, pcs, asb, aop};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pushes the expected per-cycle trace for one opcode, then pops one
    // entry per clock as the DUT steps. limit>0 truncates the trace.
    task automatic run_op(input logic [5:0] op, input int limit);
        logic [3:0] seq[$];
        exp_t       e;
        int         n;
        Opcode = op;
        seq.push_back(4'd0);
        seq.push_back(4'd1);
        case (op)
            6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07: begin
                seq.push_back(4'd2); seq.push_back(4'd5);
            end
            6'h08: begin seq.push_back(4'd3); seq.push_back(4'd5); end
            6'h09: seq.push_back(4'd4);
            6'h0A, 6'h0B: seq.push_back(4'd6);
            6'h0C: seq.push_back(4'd7);
            6'h3F: for (int k = 0; k < 20; k++) seq.push_back(4'd8);
            default: ;
        endcase
        n = (limit > 0 && limit < seq.size()) ? limit : seq.size();
        for (int i = 0; i < n; i++) begin
            e.st     = seq[i];
            e.ctrl   = model_ctrl(seq[i], op);
            e.halted = (seq[i] == 4'd8);
            e.cnt    = exp_cnt;
            sb.push_back(e);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("op%02h_state", op),  32'(State),      32'(e.st));
            check($sformatf("op%02h_ctrl", op),   32'(dut_ctrl),   32'(e.ctrl));
            check($sformatf("op%02h_halted", op), 32'(Halted),     32'(e.halted));
            check($sformatf("op%02h_count", op),  32'(InstrCount), 32'(e.cnt));
            @(posedge clk);
            @(negedge clk);
        end
        if (limit == 0 && op != 6'h3F) exp_cnt++;
    endtask

    initial begin
        reset  = 1'b0;
        Opcode = 6'h3F;
        repeat (3) @(negedge clk);
        check("rst_state",  32'(State),      32'd0);
        check("rst_ctrl",   32'(dut_ctrl),   32'd0);
        check("rst_halted", 32'(Halted),     32'd0);
        check("rst_count",  32'(InstrCount), 32'd0);

        reset = 1'b1;
        #1;
        run_op(6'h01, 0);
        run_op(6'h08, 0);
        run_op(6'h09, 0);
        run_op(6'h0B, 0);
        run_op(6'h0A, 0);
        run_op(6'h0C, 0);
        run_op(6'h02, 0);
        run_op(6'h03, 0);
        run_op(6'h04, 0);
        run_op(6'h05, 0);
        run_op(6'h06, 0);
        run_op(6'h07, 0);
        run_op(6'h00, 0);
        run_op(6'h22, 0);
        run_op(6'h3F, 0);

        // Leave HALT through reset, then abort an ADD in the middle of WB.
        reset = 1'b0;
        #1;
        check("halt_rst_state", 32'(State), 32'd0);
        @(negedge clk);
        reset   = 1'b1;
        exp_cnt = 16'd0;
        #1;
        run_op(6'h01, 3);
        check("midwb_regwrite_pre", 32'(RegWrite), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("midwb_regwrite", 32'(RegWrite),   32'd0);
        check("midwb_state",    32'(State),      32'd0);
        check("midwb_count",    32'(InstrCount), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_ctrl",  32'(dut_ctrl),   32'd0);
        check("rst_hold_state", 32'(State),      32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        run_op(6'h00, 0);

        // Preload near the top of the counter to exercise the wrap.
        force dut.r_instr_count = 16'hFFFE;
        #1;
        release dut.r_instr_count;
        exp_cnt = 16'hFFFE;
        run_op(6'h22, 0);
        run_op(6'h00, 0);
        check("wrap_count", 32'(InstrCount), 32'(exp_cnt));
        check("wrap_zero",  32'(InstrCount), 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL declare clk, input, 1: single clock; all state changes on rising edge.
REQ-002 SHALL declare reset, input, 1: asynchronous, active-low (0 = reset), the only reset.
REQ-003 SHALL declare Opcode, input, 6: driven from datapath IReg_out[31:26]; sampled only in DECODE.
REQ-004 SHALL declare outputs PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, BranchType, LUI, each 1 bit: datapath control lines.
REQ-005 SHALL declare PCSource (2), ALUSrcB (2) and ALUOp (4) outputs: datapath mux selects and ALU function.
REQ-006 SHALL declare State, output, 4: current FSM state code, for debug.
REQ-007 SHALL declare Halted, output, 1: high while in HALT.
REQ-008 SHALL declare InstrCount, output, 16: retired-instruction counter.

Function
REQ-009 SHALL implement a Moore FSM with these codes: FETCH=0, DECODE=1, EXEC=2, MEMRD=3, MEMWR=4, WB=5, BRANCH=6, JUMP=7, HALT=8. Codes 9-15 SHALL go to FETCH on the next edge.
REQ-010 SHALL use this opcode map: 00 NOP, 01 ADD, 02 SUB, 03 AND, 04 OR, 05 ADDI, 06 ORI, 07 LUI, 08 LW, 09 SW, 0A BEQ, 0B BNE, 0C J, 3F HALT; any other opcode SHALL decode as NOP.
REQ-011 SHALL use ALUOp codes ADD=0010, SUB=0110, AND=0000, OR=0001, PASSA=1000.
REQ-012 SHALL, in FETCH: IorD=0, MemRead=1, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00, PCWrite=1 (IR<=IMem[PC], PC<=PC+1); next state DECODE.
REQ-013 SHALL, in DECODE: drive all control outputs to 0, and latch Opcode into an internal register.
REQ-014 SHALL choose the state after DECODE as: ALU/immediate ops (01-07) -> EXEC; LW -> MEMRD; SW -> MEMWR; BEQ/BNE -> BRANCH; J -> JUMP; HALT -> HALT; NOP -> FETCH.
REQ-015 SHALL, in EXEC: ALUSrcA=1, with ALUSrcB/ALUOp per op: ADD 00/ADD, SUB 00/SUB, AND 00/AND, OR 00/OR, ADDI 10/ADD, ORI 11/OR, LUI 11/OR; next state WB.
REQ-016 SHALL, in MEMRD: drive all outputs 0 (the MDR captures DMem); next state WB.
REQ-017 SHALL, in MEMWR: MemWrite=1 for exactly one cycle; next state FETCH.
REQ-018 SHALL, in WB: RegWrite=1; MemtoReg=1 only for LW; LUI=1 only for the LUI opcode; next state FETCH.
REQ-019 SHALL, in BRANCH: PCWrite=1, ALUSrcA=0, ALUOp=PASSA, PCSource=00, BranchType=0 for BEQ and 1 for BNE (a taken branch overrides the PC source inside the datapath); next state FETCH.
REQ-020 SHALL, in JUMP: PCWrite=1, PCSource=10; next state FETCH.
REQ-021 SHALL, in HALT: drive all controls 0 and Halted=1, and remain in HALT until reset.
REQ-022 SHALL drive every control output not named for a state to 0 in that state.
REQ-023 SHALL make outputs combinational functions of the state register and latched opcode only, so they are glitch-free relative to Opcode changes.
REQ-024 SHALL increment InstrCount by 1 on the edge leaving the final state of each instruction (WB, MEMWR, BRANCH, JUMP, or DECODE->FETCH for NOP), wrap 0xFFFF->0x0000, and not count HALT.
REQ-025 SHALL give these latencies in cycles: NOP 2; SW/BEQ/BNE/J 3; ALU/imm/LW 4.

Reset
REQ-026 SHALL, while reset=0, hold State=FETCH, InstrCount=0, latched opcode=0, and force every control output and Halted to 0, regardless of clk.
REQ-027 SHALL abandon an instruction immediately when reset is asserted mid-instruction, with no RegWrite/MemWrite/PCWrite pulse during or after assertion.
REQ-028 SHALL perform FETCH on the first rising edge after reset deasserts.

Verification
REQ-029 Bench SHALL cover: reset release, Opcode=01 -> States 0,1,2,5,0; EXEC ALUSrcA=1 ALUSrcB=00 ALUOp=0010; WB RegWrite=1; InstrCount=1.
REQ-030 Bench SHALL cover: Opcode=08 -> 0,1,3,5 with WB MemtoReg=1; Opcode=09 -> 0,1,4 with MemWrite high exactly 1 cycle.
REQ-031 Bench SHALL cover: Opcode=0B -> BRANCH with BranchType=1 PCWrite=1 ALUOp=1000; Opcode=0C -> JUMP with PCSource=10.
REQ-032 Bench SHALL cover: Opcode=3F -> HALT; Halted=1 for 20 cycles, InstrCount frozen; Opcode=22 -> NOP path 0,1,0.
REQ-033 Bench SHALL cover: reset=0 asserted mid-WB (between edges) -> RegWrite drops in the same delta, State=0, InstrCount=0.
REQ-034 Bench SHALL cover: preload 65535 NOPs -> InstrCount wraps to 0x0000.
